// File: rtl/filtro_promedio_5x5_pkg.sv
// Shared constants and state encoding for the 5x5 averaging filter.
// Window geometry and the 1/25 scale approximation live here.
package filtro_promedio_5x5_pkg;

  localparam int ANCHO_PIXEL    = 8;
  localparam int ANCHO_FILA     = 64;

  localparam int NUM_FILAS      = 5;
  localparam int NUM_COLUMNAS   = 8;
  localparam int ANCHO_VENTANA  = 5;
  localparam int NUM_POSICIONES = NUM_COLUMNAS - ANCHO_VENTANA + 1;

  localparam int BITS_COLUMNA   = $clog2(NUM_COLUMNAS);
  localparam int BITS_POSICION  = $clog2(NUM_POSICIONES);
  localparam int BITS_SUMA_COL  = 11;
  localparam int BITS_ACC       = 13;
  localparam int BITS_PRODUCTO  = 19;

  // 41/1024 is close enough to 1/25 that 25*255 still maps to 255
  localparam int ESCALA_MULT    = 41;
  localparam int ESCALA_DESPL   = 10;

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    ESPERA = 3'd1,
    CARGA  = 3'd2,
    SUMA   = 3'd3,
    ESCALA = 3'd4,
    SALIDA = 3'd5
  } estado_t;

endpackage

// File: rtl/filtro_promedio_5x5_suma_columna.sv
// Combinational sum of the five bytes of one window column.
module filtro_promedio_5x5_suma_columna
  import filtro_promedio_5x5_pkg::*;
#(
  parameter int BITS_FILA  = ANCHO_FILA,
  parameter int BITS_PIXEL = ANCHO_PIXEL
) (
  input  logic [BITS_FILA-1:0]     fila1_i,
  input  logic [BITS_FILA-1:0]     fila2_i,
  input  logic [BITS_FILA-1:0]     fila3_i,
  input  logic [BITS_FILA-1:0]     fila4_i,
  input  logic [BITS_FILA-1:0]     fila5_i,
  input  logic [BITS_COLUMNA-1:0]  columna_i,
  output logic [BITS_SUMA_COL-1:0] suma_o
);

  localparam int BITS_BASE = $clog2(BITS_FILA);

  logic [BITS_BASE-1:0] base;

  always_comb begin
    base   = BITS_BASE'(columna_i) * BITS_BASE'(BITS_PIXEL);
    suma_o = BITS_SUMA_COL'(fila1_i[base +: BITS_PIXEL])
           + BITS_SUMA_COL'(fila2_i[base +: BITS_PIXEL])
           + BITS_SUMA_COL'(fila3_i[base +: BITS_PIXEL])
           + BITS_SUMA_COL'(fila4_i[base +: BITS_PIXEL])
           + BITS_SUMA_COL'(fila5_i[base +: BITS_PIXEL]);
  end

endmodule

// File: rtl/filtro_promedio_5x5.sv
// 5x5 mean filter: copies a 5-row window, slides across 4 positions and
// emits one averaged pixel per position over a valid/accept handshake.
//
// state  | meaning
// REPOSO | idle, waiting for iniciar_proceso
// ESPERA | waiting for ventana_lista to copy the rows
// CARGA  | requests next window upstream, clears accumulator
// SUMA   | accumulates one column sum per cycle (5 cycles)
// ESCALA | multiply-shift of the accumulator into pixel register
// SALIDA | pixel_valido held until pixel_aceptado
module filtro_promedio_5x5
  import filtro_promedio_5x5_pkg::*;
#(
  parameter int BITS_FILA            = ANCHO_FILA,
  parameter int BITS_PIXEL           = ANCHO_PIXEL,
  parameter int MULT_ESCALA          = ESCALA_MULT,
  parameter int DESPL_ESCALA         = ESCALA_DESPL,
  parameter int TOTAL_VENTANAS       = 64,
  parameter int BITS_CUENTA_VENTANAS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iniciar_proceso,
  input  logic                  ventana_lista,
  input  logic [BITS_FILA-1:0]  fila1,
  input  logic [BITS_FILA-1:0]  fila2,
  input  logic [BITS_FILA-1:0]  fila3,
  input  logic [BITS_FILA-1:0]  fila4,
  input  logic [BITS_FILA-1:0]  fila5,
  output logic                  actualizar_ventana,
  output logic [BITS_PIXEL-1:0] pixel_salida,
  output logic                  pixel_valido,
  input  logic                  pixel_aceptado,
  output logic                  ocupado,
  output logic                  proceso_terminado
);

  estado_t                         estado_q, estado_d;
  logic [BITS_FILA-1:0]            copia_q [NUM_FILAS];
  logic [BITS_FILA-1:0]            copia_d [NUM_FILAS];
  logic [BITS_ACC-1:0]             acc_q, acc_d;
  logic [BITS_POSICION-1:0]        pos_q, pos_d;
  logic [BITS_COLUMNA-1:0]         k_q, k_d;
  logic [BITS_CUENTA_VENTANAS-1:0] cuenta_q, cuenta_d;
  logic [BITS_PIXEL-1:0]           pixel_q, pixel_d;
  logic                            fin_q, fin_d;

  logic [BITS_COLUMNA-1:0]         columna;
  logic [BITS_SUMA_COL-1:0]        suma_col;
  logic [BITS_PRODUCTO-1:0]        producto;
  logic [BITS_CUENTA_VENTANAS:0]   cuenta_sig;

  assign columna = BITS_COLUMNA'(pos_q) + k_q;

  filtro_promedio_5x5_suma_columna #(
    .BITS_FILA  (BITS_FILA),
    .BITS_PIXEL (BITS_PIXEL)
  ) u_suma_columna (
    .fila1_i   (copia_q[0]),
    .fila2_i   (copia_q[1]),
    .fila3_i   (copia_q[2]),
    .fila4_i   (copia_q[3]),
    .fila5_i   (copia_q[4]),
    .columna_i (columna),
    .suma_o    (suma_col)
  );

  assign producto   = BITS_PRODUCTO'(acc_q) * BITS_PRODUCTO'(MULT_ESCALA);
  assign cuenta_sig = {1'b0, cuenta_q} + 1'b1;

  always_comb begin
    estado_d = estado_q;
    copia_d  = copia_q;
    acc_d    = acc_q;
    pos_d    = pos_q;
    k_d      = k_q;
    cuenta_d = cuenta_q;
    pixel_d  = pixel_q;
    fin_d    = 1'b0;

    case (estado_q)
      REPOSO: begin
        if (iniciar_proceso) begin
          cuenta_d = '0;
          estado_d = ESPERA;
        end
      end
      ESPERA: begin
        if (ventana_lista) begin
          copia_d[0] = fila1;
          copia_d[1] = fila2;
          copia_d[2] = fila3;
          copia_d[3] = fila4;
          copia_d[4] = fila5;
          pos_d      = '0;
          estado_d   = CARGA;
        end
      end
      CARGA: begin
        acc_d    = '0;
        k_d      = '0;
        estado_d = SUMA;
      end
      SUMA: begin
        acc_d = acc_q + BITS_ACC'(suma_col);
        k_d   = k_q + 1'b1;
        if (k_q == BITS_COLUMNA'(ANCHO_VENTANA - 1)) begin
          estado_d = ESCALA;
        end
      end
      ESCALA: begin
        pixel_d  = BITS_PIXEL'(producto >> DESPL_ESCALA);
        estado_d = SALIDA;
      end
      SALIDA: begin
        if (pixel_aceptado) begin
          if (pos_q != BITS_POSICION'(NUM_POSICIONES - 1)) begin
            pos_d    = pos_q + 1'b1;
            acc_d    = '0;
            k_d      = '0;
            estado_d = SUMA;
          end else if (cuenta_sig < (BITS_CUENTA_VENTANAS + 1)'(TOTAL_VENTANAS)) begin
            cuenta_d = cuenta_sig[BITS_CUENTA_VENTANAS-1:0];
            estado_d = ESPERA;
          end else begin
            fin_d    = 1'b1;
            estado_d = REPOSO;
          end
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
      for (int i = 0; i < NUM_FILAS; i++) begin
        copia_q[i] <= '0;
      end
      acc_q    <= '0;
      pos_q    <= '0;
      k_q      <= '0;
      cuenta_q <= '0;
      pixel_q  <= '0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      copia_q  <= copia_d;
      acc_q    <= acc_d;
      pos_q    <= pos_d;
      k_q      <= k_d;
      cuenta_q <= cuenta_d;
      pixel_q  <= pixel_d;
      fin_q    <= fin_d;
    end
  end

  assign actualizar_ventana = (estado_q == CARGA);
  assign pixel_valido       = (estado_q == SALIDA);
  assign ocupado            = (estado_q != REPOSO);
  assign pixel_salida       = pixel_q;
  assign proceso_terminado  = fin_q;

endmodule

// File: tb/tb_filtro_promedio_5x5.sv
// Scoreboard bench for filtro_promedio_5x5 with a two-window run length.
module tb_filtro_promedio_5x5;

  logic        clk = 1'b0;
  logic        reset;
  logic        iniciar_proceso;
  logic        ventana_lista;
  logic [63:0] fila1, fila2, fila3, fila4, fila5;
  logic        actualizar_ventana;
  logic [7:0]  pixel_salida;
  logic        pixel_valido;
  logic        pixel_aceptado;
  logic        ocupado;
  logic        proceso_terminado;

  always #5 clk = ~clk;

  filtro_promedio_5x5 #(.TOTAL_VENTANAS(2)) u_dut (
    .clk                (clk),
    .reset              (reset),
    .iniciar_proceso    (iniciar_proceso),
    .ventana_lista      (ventana_lista),
    .fila1              (fila1),
    .fila2              (fila2),
    .fila3              (fila3),
    .fila4              (fila4),
    .fila5              (fila5),
    .actualizar_ventana (actualizar_ventana),
    .pixel_salida       (pixel_salida),
    .pixel_valido       (pixel_valido),
    .pixel_aceptado     (pixel_aceptado),
    .ocupado            (ocupado),
    .proceso_terminado  (proceso_terminado)
  );

  localparam logic [63:0] FILA_FF    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FILA_100   = 64'h6464_6464_6464_6464;
  localparam logic [63:0] FILA_0     = 64'h0;
  localparam logic [63:0] FILA_RAMPA = 64'h463C_3228_1E14_0A00;
  localparam logic [63:0] FILA_BASURA = 64'hA55A_F00F_1234_C3C3;

  logic [7:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_act = 0;

  task automatic check(input string nombre, input int actual, input int esperado);
    total++;
    if (actual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
    end
  endtask

  // Monitor: every accepted pixel is compared against the queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (actualizar_ventana) n_act++;
      if (pixel_valido && pixel_aceptado) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pixel_inesperado: got %0d expected none", pixel_salida);
        end else begin
          check("pixel", int'(pixel_salida), int'(exp_q.pop_front()));
        end
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_filas(input logic [63:0] v);
    fila1 = v; fila2 = v; fila3 = v; fila4 = v; fila5 = v;
  endtask

  task automatic arrancar(input logic [63:0] w0, input logic [63:0] w1);
    int n;
    set_filas(w0);
    ventana_lista   = 1'b1;
    iniciar_proceso = 1'b1;
    tick();
    iniciar_proceso = 1'b0;
    tick();
    check("actualizar_tras_latch", int'(actualizar_ventana), 1);
    set_filas(w1);
    n = 0;
    while (!pixel_valido && n < 50) begin
      tick();
      n++;
    end
    check("latencia_primer_pixel", n, 7);
  endtask

  task automatic correr(input logic [63:0] w0, input logic [63:0] w1,
                        input logic [31:0] e0, input logic [31:0] e1, input bit bp);
    int n, act0, acc0;
    logic [7:0] fijo;
    bit estable;
    for (int i = 0; i < 4; i++) exp_q.push_back(e0[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(e1[8*i +: 8]);
    act0 = n_act;
    acc0 = n_acc;
    arrancar(w0, w1);
    if (bp) begin
      n = 0;
      while (n_acc < acc0 + 6 && n < 400) begin
        tick();
        n++;
      end
      pixel_aceptado = 1'b0;
      n = 0;
      while (!pixel_valido && n < 50) begin
        tick();
        n++;
      end
      check("bp_pixel_presente", int'(pixel_valido), 1);
      fijo = pixel_salida;
      set_filas(FILA_BASURA);
      estable = 1'b1;
      repeat (20) begin
        tick();
        if (!pixel_valido || pixel_salida != fijo) estable = 1'b0;
      end
      check("bp_estable", int'(estable), 1);
      check("bp_sin_aceptar", n_acc - acc0, 6);
      pixel_aceptado = 1'b1;
    end
    n = 0;
    while (!proceso_terminado && n < 400) begin
      tick();
      n++;
    end
    check("terminado_pulso", int'(proceso_terminado), 1);
    check("terminado_ocupado", int'(ocupado), 0);
    tick();
    check("terminado_un_ciclo", int'(proceso_terminado), 0);
    check("actualizaciones", n_act - act0, 2);
    check("pixeles_por_corrida", n_acc - acc0, 8);
    repeat (10) tick();
    check("tercera_ventana_ignorada", int'(ocupado), 0);
    check("sin_actualizar_extra", n_act - act0, 2);
    ventana_lista = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, acc0;
    reset           = 1'b1;
    iniciar_proceso = 1'b0;
    ventana_lista   = 1'b0;
    pixel_aceptado  = 1'b1;
    set_filas(FILA_0);
    repeat (3) tick();
    check("reset_valido", int'(pixel_valido), 0);
    check("reset_pixel", int'(pixel_salida), 0);
    check("reset_ocupado", int'(ocupado), 0);
    check("reset_actualizar", int'(actualizar_ventana), 0);
    reset = 1'b0;
    tick();

    correr(FILA_FF, FILA_100, 32'hFFFF_FFFF, 32'h6464_6464, 1'b0);
    correr(FILA_0, FILA_RAMPA, 32'h0, 32'h3228_1E14, 1'b1);

    // Reset during SUMA of the second position
    exp_q.push_back(8'd100);
    acc0 = n_acc;
    arrancar(FILA_100, FILA_100);
    n = 0;
    while (n_acc < acc0 + 1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    reset = 1'b1;
    tick();
    check("abort_valido", int'(pixel_valido), 0);
    check("abort_pixel", int'(pixel_salida), 0);
    check("abort_ocupado", int'(ocupado), 0);
    check("abort_actualizar", int'(actualizar_ventana), 0);
    check("abort_terminado", int'(proceso_terminado), 0);
    check("abort_cola_vacia", exp_q.size(), 0);
    reset         = 1'b0;
    ventana_lista = 1'b0;
    tick();

    correr(FILA_RAMPA, FILA_FF, 32'h3228_1E14, 32'hFFFF_FFFF, 1'b0);
    check("cola_final_vacia", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filtro_promedio_5x5.md
Name: filtro_promedio_5x5

Overview:
- Downstream consumer of the 5-row window stage (manejo_ventana).
- Copies the five 64-bit rows, slides a 5x5 pixel window across the 8 columns (4 positions), and emits one 8-bit averaged pixel per position over a valid/accept handshake.
- Requests the next window from upstream as soon as its local copy is taken, so upstream refill overlaps computation.

Parameters:
- BITS_FILA, 64, row width (8 pixels of BITS_PIXEL).
- BITS_PIXEL, 8, pixel width.
- MULT_ESCALA, 41, scale multiplier (approximates 1/25 with DESPL_ESCALA).
- DESPL_ESCALA, 10, right shift applied after multiply.
- TOTAL_VENTANAS, 64, windows processed per run.
- BITS_CUENTA_VENTANAS, 8, width of the window counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar_proceso  in  1  one-cycle start pulse.
- ventana_lista  in  1  upstream window rows valid.
- fila1..fila5  in  BITS_FILA each  window rows. Column c = bits [8c+7:8c].
- actualizar_ventana  out  1  one-cycle pulse requesting the next window.
- pixel_salida  out  BITS_PIXEL  averaged pixel.
- pixel_valido  out  1  pixel_salida valid.
- pixel_aceptado  in  1  downstream accept.
- ocupado  out  1  high in any state except REPOSO.
- proceso_terminado  out  1  one-cycle pulse after the last pixel of the last window.

Behaviour:
- Reset:
  - State goes to REPOSO.
  - All outputs are 0; row copy, accumulator, position and window counters are 0.
  - A reset asserted mid-operation aborts immediately; no pulse is emitted.
- States:
  - REPOSO: iniciar_proceso goes to ESPERA and clears the window counter. iniciar_proceso is ignored in every other state.
  - ESPERA: on ventana_lista=1, latch fila1..fila5 into the local copy, set position p=0, go to CARGA. ventana_lista is ignored outside ESPERA.
  - CARGA: lasts 1 cycle. actualizar_ventana=1 (Moore output, exactly one cycle per window). Accumulator cleared, column index k=0. Go to SUMA.
  - SUMA: lasts 5 cycles. Each cycle adds the column sum of column p+k (5 bytes, one from each row) to the accumulator, then k++. After k=4 go to ESCALA.
  - ESCALA: lasts 1 cycle. Registers pixel_salida = (acc*MULT_ESCALA) >> DESPL_ESCALA, truncated to BITS_PIXEL. Go to SALIDA.
  - SALIDA: pixel_valido=1, with pixel_salida held stable until pixel_aceptado=1 is sampled. Backpressure may last indefinitely. On acceptance, pixel_valido drops on the next cycle, then:
    - If p<3: p++, clear accumulator, k=0, go to SUMA.
    - Else if window counter+1 < TOTAL_VENTANAS: increment the counter, go to ESPERA.
    - Else: pulse proceso_terminado for one cycle, go to REPOSO.
- Widths:
  - Accumulator is 13 bits (max 25*255 = 6375).
  - Product is 19 bits.
  - With the defaults, the result is at most 255 and never saturates.
- Latency:
  - ventana_lista sampled at edge E0 → pixel_valido high after E7.
  - Acceptance at edge A → next pixel_valido high after A+6.
  - Per window with immediate acceptance: 1 (CARGA) + 4 × 7 cycles.
- Simultaneous events:
  - pixel_aceptado while pixel_valido=0 is ignored.
  - ventana_lista held high continuously is latched once per ESPERA visit only.

Decomposition:
- Shared package:
  - Pixel and row width constants.
  - Window geometry: 5 rows, 8 columns, 4 positions.
  - Scale constants.
  - State encoding for REPOSO, ESPERA, CARGA, SUMA, ESCALA, SALIDA.
- One sub-module, suma_columna: combinational sum of five BITS_PIXEL bytes to a 11-bit result, selected by column index.
- FSM, counters and registers stay in filtro_promedio_5x5.

Test Plan:
- All rows 0xFF..FF, pixel_aceptado tied 1 → 4 pixels of 255, one actualizar_ventana pulse, first pixel_valido 7 edges after ventana_lista is sampled.
- All bytes 100 → 4 pixels of 100; all bytes 0 → 4 pixels of 0.
- Column c byte = 10*c in every row → pixels 20, 30, 40, 50 in order (e.g. sum 500 → 20500 >> 10 = 20).
- Hold pixel_aceptado=0 for 20 cycles on pixel 2 → pixel_valido stays 1 and pixel_salida is stable. Change fila1..fila5 during this time → output is unaffected, since the local copy is used.
- TOTAL_VENTANAS=2, two windows supplied → 8 pixels, then a one-cycle proceso_terminado, ocupado drops, and a third ventana_lista is ignored until iniciar_proceso.
- Assert reset during SUMA of the second position → next cycle all outputs are 0 and state is REPOSO. A subsequent iniciar_proceso restarts cleanly with p=0.
